mem_arbiter: RTL and testbench

Single-port arbiter sharing the 256x8 unified memory between instruction fetch (IF) and data access (DM: load/store/stack/vector reads). Sits between the two requesters and the `memory` block and performs one access per cycle. After reset it runs a one-cycle boot read of the reset vector. Fetch is protected from starvation by a bounded data burst counter.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter: bus widths, the
// arbiter state encoding and the default reset-vector address.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // BOOT performs the single reset-vector read; RUN arbitrates IF vs DM.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    localparam logic [ADDR_W-1:0] BOOT_ADDR_DEFAULT = 8'h00;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing the 256x8 unified memory between instruction
// fetch (IF) and data access (DM). One access per cycle, combinational grant.
// After reset a one-cycle boot read captures the reset-vector byte. Data has
// priority under contention, but a saturating burst counter forces an IF grant
// after MAX_DATA_BURST consecutive DM grants so fetch cannot starve.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BOOT_ADDR      = BOOT_ADDR_DEFAULT,
    parameter int                MAX_DATA_BURST = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_out_data,
    output logic [DATA_W-1:0] boot_pc,
    output logic              boot_done
);

    localparam int               CNT_W   = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

    arb_state_t        state_reg;
    logic [CNT_W-1:0]  burst_cnt_reg;
    logic [DATA_W-1:0] boot_pc_reg;
    logic              boot_done_reg;

    logic run;
    logic burst_full;

    assign run        = (state_reg == RUN);
    assign burst_full = (burst_cnt_reg == CNT_MAX);

    // Fixed priority: DM wins a contended cycle unless the burst limit is hit.
    assign if_gnt = run && if_req && (!dm_req || burst_full);
    assign dm_gnt = run && dm_req && !(if_req && burst_full);

    // Memory port steering; idle values are all-zero so the bus is quiet.
    // The boot read is gated by rst so nothing is strobed while in reset.
    always_comb begin
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;
        if (state_reg == BOOT) begin
            if (rst) begin
                mem_address = BOOT_ADDR;
                mem_read    = 1'b1;
            end
        end else if (if_gnt) begin
            mem_address = if_addr;
            mem_read    = 1'b1;
        end else if (dm_gnt) begin
            mem_address = dm_addr;
            if (dm_we) begin
                mem_write      = 1'b1;
                mem_write_data = dm_wdata;
            end else begin
                mem_read = 1'b1;
            end
        end
    end

    // Read data is forwarded only to the requester that owns this cycle.
    always_comb begin
        if_rdata = if_gnt ? mem_out_data : '0;
        dm_rdata = (dm_gnt && !dm_we) ? mem_out_data : '0;
    end

    // State machine: boot capture, then starvation-counter bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= BOOT;
            burst_cnt_reg <= '0;
            boot_pc_reg   <= '0;
            boot_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    boot_pc_reg   <= mem_out_data;
                    boot_done_reg <= 1'b1;
                    burst_cnt_reg <= '0;
                    state_reg     <= RUN;
                end
                RUN: begin
                    // Counter tracks DM grants taken while IF was waiting.
                    if (if_gnt || !if_req) begin
                        burst_cnt_reg <= '0;
                    end else if (dm_gnt && !burst_full) begin
                        burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= BOOT;
            endcase
        end
    end

    assign boot_pc   = boot_pc_reg;
    assign boot_done = boot_done_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. A bench-side 256x8 memory (combinational
// read, posedge write) is wired to the arbiter. An abstract reference model
// (booted flag, count of DM wins while IF waits, shadow memory) predicts every
// output on every negedge; directed scenarios pin the model with literals, then
// randomized requesters (honouring the hold-until-grant rule) and sporadic
// resets exercise the arbiter at length.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int          MAXB  = 3;
    localparam logic [7:0]  BADDR = 8'h00;

    logic       clk;
    logic       rst;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_gnt;
    logic [7:0] if_rdata;
    logic       dm_req;
    logic       dm_we;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdata;
    logic       dm_gnt;
    logic [7:0] dm_rdata;
    logic [7:0] mem_address;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_write_data;
    logic [7:0] mem_out_data;
    logic [7:0] boot_pc;
    logic       boot_done;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(
        .BOOT_ADDR      (BADDR),
        .MAX_DATA_BURST (MAXB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rdata       (if_rdata),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_gnt         (dm_gnt),
        .dm_rdata       (dm_rdata),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_out_data   (mem_out_data),
        .boot_pc        (boot_pc),
        .boot_done      (boot_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench memory: combinational read, write commits at the posedge.
    logic [7:0] mem_array [256];
    assign mem_out_data = mem_array[mem_address];
    always @(posedge clk) begin
        if (mem_write) mem_array[mem_address] <= mem_write_data;
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];
    bit         m_booted;
    int         m_streak;      // DM wins in a row while IF has been waiting
    logic [7:0] m_boot_pc;
    logic [1:0] exp_g;         // {if wins, dm wins}

    function automatic logic [1:0] pick(bit booted, logic ir, logic dr, int streak);
        if (!booted)       return 2'b00;
        if (ir && dr)      return (streak >= MAXB) ? 2'b10 : 2'b01;
        if (ir)            return 2'b10;
        if (dr)            return 2'b01;
        return 2'b00;
    endfunction

    assign exp_g = pick(m_booted, if_req, dm_req, m_streak);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_booted  <= 1'b0;
            m_streak  <= 0;
            m_boot_pc <= 8'h00;
        end else if (!m_booted) begin
            m_boot_pc <= ref_mem[BADDR];
            m_booted  <= 1'b1;
            m_streak  <= 0;
        end else begin
            if (exp_g[0] && dm_we) ref_mem[dm_addr] <= dm_wdata;
            if (exp_g[1] || !if_req)  m_streak <= 0;
            else if (exp_g[0])        m_streak <= (m_streak + 1 > MAXB) ? MAXB : m_streak + 1;
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    logic       e_ig, e_dg, e_rd, e_wr;
    logic [7:0] e_addr, e_wd, e_ird, e_drd, e_bpc;
    logic       e_bd;
    always @(negedge clk) begin
        e_ig = 0; e_dg = 0; e_rd = 0; e_wr = 0;
        e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0;
        e_bpc = 0; e_bd = 0;
        if (rst) begin
            e_bpc = m_boot_pc;
            e_bd  = m_booted;
            if (!m_booted) begin
                e_rd = 1; e_addr = BADDR;
            end else if (exp_g[1]) begin
                e_ig = 1; e_rd = 1; e_addr = if_addr; e_ird = ref_mem[if_addr];
            end else if (exp_g[0]) begin
                e_dg = 1; e_addr = dm_addr;
                if (dm_we) begin e_wr = 1; e_wd = dm_wdata; end
                else begin e_rd = 1; e_drd = ref_mem[dm_addr]; end
            end
        end
        chk("if_gnt",         8'(if_gnt),    8'(e_ig));
        chk("dm_gnt",         8'(dm_gnt),    8'(e_dg));
        chk("mem_read",       8'(mem_read),  8'(e_rd));
        chk("mem_write",      8'(mem_write), 8'(e_wr));
        chk("mem_address",    mem_address,   e_addr);
        chk("mem_write_data", mem_write_data, e_wd);
        chk("if_rdata",       if_rdata,      e_ird);
        chk("dm_rdata",       dm_rdata,      e_drd);
        chk("boot_pc",        boot_pc,       e_bpc);
        chk("boot_done",      8'(boot_done), 8'(e_bd));
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] cont_exp [5];
    logic       last_if, last_dm;

    initial begin
        rst = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem_array[i] <= 8'h00;
            ref_mem[i]   <= 8'h00;
        end
        mem_array[8'h00] <= 8'h3C; ref_mem[8'h00] <= 8'h3C;
        mem_array[8'h20] <= 8'h55; ref_mem[8'h20] <= 8'h55;
        mem_array[8'h40] <= 8'h77; ref_mem[8'h40] <= 8'h77;

        // Reset held for two cycles.
        step(); step();
        @(negedge clk);
        chk("rst_boot_done", 8'(boot_done), 8'h00);
        chk("rst_mem_read",  8'(mem_read),  8'h00);

        // Release: boot cycle, with an IF request pending that must wait.
        step();
        rst = 1'b1; if_req = 1; if_addr = 8'h20;
        @(negedge clk);
        chk("boot_read",  8'(mem_read), 8'h01);
        chk("boot_addr",  mem_address,  8'h00);
        chk("boot_nogrant", 8'(if_gnt), 8'h00);
        step();
        @(negedge clk);
        chk("boot_pc_lit",   boot_pc,        8'h3C);
        chk("boot_done_lit", 8'(boot_done),  8'h01);
        chk("first_if_rd",   if_rdata,       8'h55);
        $display("[TB] boot: boot_pc=%02h boot_done=%0d", boot_pc, boot_done);

        // DM write AA -> 0x10, then IF reads it back.
        step();
        if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 8'h10; dm_wdata = 8'hAA;
        @(negedge clk);
        chk("dmw_gnt",   8'(dm_gnt),    8'h01);
        chk("dmw_write", 8'(mem_write), 8'h01);
        $display("[TB] dm write addr=10 data=aa gnt=%0d", dm_gnt);
        step();
        dm_req = 0; dm_we = 0; if_req = 1; if_addr = 8'h10;
        @(negedge clk);
        chk("ifr_gnt",   8'(if_gnt), 8'h01);
        chk("ifr_rdata", if_rdata,   8'hAA);
        $display("[TB] if read addr=10 data=%02h", if_rdata);

        // Five contended cycles: DM,DM,DM,IF,DM.
        cont_exp[0] = 2'b01; cont_exp[1] = 2'b01; cont_exp[2] = 2'b01;
        cont_exp[3] = 2'b10; cont_exp[4] = 2'b01;
        step();
        if_req = 1; if_addr = 8'h05; dm_req = 1; dm_we = 0; dm_addr = 8'h20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("contention_gnt", 8'({if_gnt, dm_gnt}), 8'(cont_exp[k]));
            $display("[TB] contention cycle %0d: if_gnt=%0d dm_gnt=%0d", k, if_gnt, dm_gnt);
            if (k < 4) step();
        end

        // Idle cycle.
        step();
        if_req = 0; dm_req = 0;
        @(negedge clk);
        chk("idle_read",  8'(mem_read),  8'h00);
        chk("idle_write", 8'(mem_write), 8'h00);
        chk("idle_gnts",  8'({if_gnt, dm_gnt}), 8'h00);
        chk("idle_rdata", {if_rdata[3:0], dm_rdata[3:0]} | {if_rdata[7:4], dm_rdata[7:4]}, 8'h00);
        $display("[TB] idle: read=%0d write=%0d", mem_read, mem_write);

        // Simultaneous DM read 0x20 and IF read 0x30.
        step();
        dm_req = 1; dm_we = 0; dm_addr = 8'h20; if_req = 1; if_addr = 8'h30;
        @(negedge clk);
        chk("sim_dm_gnt",   8'(dm_gnt), 8'h01);
        chk("sim_dm_rdata", dm_rdata,   8'h55);
        chk("sim_if_rdata", if_rdata,   8'h00);
        $display("[TB] simultaneous c1: dm_rdata=%02h if_gnt=%0d", dm_rdata, if_gnt);
        step();
        dm_req = 0;
        @(negedge clk);
        chk("sim_if_gnt",   8'(if_gnt), 8'h01);
        chk("sim_if_rd30",  if_rdata,   8'h00);
        $display("[TB] simultaneous c2: if_gnt=%0d if_rdata=%02h", if_gnt, if_rdata);

        // Reset asserted in the middle of a DM write to 0x40.
        step();
        if_req = 0; dm_req = 1; dm_we = 1; dm_addr = 8'h40; dm_wdata = 8'h99;
        #2;
        chk("mid_write_before", 8'(mem_write), 8'h01);
        rst = 1'b0;
        #1;
        chk("mid_write_drop", 8'(mem_write), 8'h00);
        chk("mid_gnt_drop",   8'(dm_gnt),    8'h00);
        step();
        rst = 1'b1; dm_req = 0; dm_we = 0;
        @(negedge clk);
        chk("mid_mem40",      mem_array[8'h40], 8'h77);
        chk("reboot_read",    8'(mem_read),     8'h01);
        chk("reboot_pending", 8'(boot_done),    8'h00);
        step();
        @(negedge clk);
        chk("reboot_done", 8'(boot_done), 8'h01);
        chk("reboot_pc",   boot_pc,       8'h3C);
        $display("[TB] reset mid-write: M[40]=%02h boot_pc=%02h", mem_array[8'h40], boot_pc);

        // Randomized traffic with sporadic resets.
        last_if = 1; last_dm = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst = 1'b0;
            if (!if_req || last_if) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 8'($urandom_range(0, 63));
            end
            if (!dm_req || last_dm) begin
                dm_req   = ($urandom_range(0, 3) != 0);
                dm_we    = ($urandom_range(0, 1) != 0);
                dm_addr  = 8'($urandom_range(0, 63));
                dm_wdata = 8'($urandom);
            end
            @(negedge clk);
            last_if = if_gnt;
            last_dm = dm_gnt;
        end
        $display("[TB] random phase complete: 3000 cycles");

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
